bcd_serial_adder_ctrl: RTL

Digit-serial BCD adder controller: accepts two DIGITS-digit packed-BCD operands plus carry-in through a start/ready handshake, then sequences one shared single-digit BCD add stage over DIGITS cycles, least-significant digit first. It owns the operand shift registers, the inter-digit carry flop, the result shift register and the control FSM. It sits between the operand-entry logic and the result display/storage path, and replaces a DIGITS-wide ripple BCD adder when area matters more than latency.

---
 rtl/bcd_serial_adder_ctrl_pkg.sv | 19 +
 rtl/bcd_serial_adder_ctrl_digit_add.sv | 34 +++
 rtl/bcd_serial_adder_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the digit-serial BCD adder and its single-digit
// add stage: BCD digit width, the largest legal digit value, the decimal
// correction constant and the controller state encoding.
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder with decimal correction.
//   a, b : input digits (values above 9 are accepted and run through the
//          same rule; the caller is responsible for flagging them)
//   ci   : carry in
//   s    : corrected result digit
//   co   : decimal carry out
// ---------------------------------------------------------------------------
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    if (raw > {1'b0, BCD_MAX}) begin
      // Adding 6 skips the six unused codes; the 4-bit add wraps mod 16.
      s  = raw[BCD_W-1:0] + BCD_CORR[BCD_W-1:0];
      co = 1'b1;
    end else begin
      s  = raw[BCD_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder_ctrl
// Digit-serial packed-BCD adder. One shared bcd_digit_add stage is stepped
// over DIGITS cycles, least-significant digit first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; accepted only while ready is high
//   a_in, b_in : packed BCD operands (digit 0 in [3:0]), sampled on accept
//   cin        : carry into digit 0, sampled on accept
//   ready      : controller idle
//   busy       : digit sequencing in progress
//   done       : one-cycle pulse; sum/cout/err valid in this cycle
//   sum, cout  : registered result, held until the next accept
//   err        : at least one operand digit exceeded 9 (cleared on accept)
// ---------------------------------------------------------------------------
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a_in,
  input  logic [BCD_W*DIGITS-1:0] b_in,
  input  logic                    cin,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    err
);

  localparam int                W     = BCD_W * DIGITS;
  localparam int                CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIGITS - 1);

  state_t           state;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] dig_s;
  logic             dig_co;

  function automatic logic has_bad_digit(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[i*BCD_W +: BCD_W] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  bcd_digit_add u_digit (
    .a  (a_sh[BCD_W-1:0]),
    .b  (b_sh[BCD_W-1:0]),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  // Handshake flags come from the state register alone.
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            err   <= has_bad_digit(a_in) | has_bad_digit(b_in);
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // New digit enters at the top so digit 0 lands in [3:0] after
          // DIGITS shifts.
          a_sh  <= a_sh >> BCD_W;
          b_sh  <= b_sh >> BCD_W;
          sum   <= {dig_s, sum[W-1:BCD_W]};
          carry <= dig_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= dig_co;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
